dds_sweep_controller: RTL and testbench

//  Sequences the DDS tuning word: linear frequency sweep (start code, signed step, point count, dwell)
//  or a fixed code. Sits between the SPI command decoder and the dds core; its dds_code replaces a directly loaded code.

---
 rtl/dds_sweep_controller.sv | 191 +++++++++++++++++++
 tb/tb_dds_sweep_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller: sequences the DDS tuning word.
// It either runs a linear frequency sweep or applies a fixed code.
// A sweep is set by a start code, a signed step, a point count and a dwell.
// A sticky interrupt is raised when a sweep completes.
// Optional feature: define DDS_SWEEP_CONTINUOUS_EN to add the cfg_continuous input.
// With cfg_continuous set, the sweep restarts after its last point.
module dds_sweep_controller #(
  parameter int unsigned CODE_WIDTH   = 32,
  parameter int unsigned POINTS_WIDTH = 16,
  parameter int unsigned DWELL_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CODE_WIDTH-1:0]   cfg_start_code,
  input  logic [CODE_WIDTH-1:0]   cfg_step_code,
  input  logic [POINTS_WIDTH-1:0] cfg_points,
  input  logic [DWELL_WIDTH-1:0]  cfg_dwell,
`ifdef DDS_SWEEP_CONTINUOUS_EN
  input  logic                    cfg_continuous,
`endif
  input  logic                    fixed_we,
  input  logic [CODE_WIDTH-1:0]   fixed_code,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    irq_clear,
  output logic [CODE_WIDTH-1:0]   dds_code,
  output logic                    code_strobe,
  output logic                    busy,
  output logic [POINTS_WIDTH-1:0] point_index,
  output logic                    interrupt
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [CODE_WIDTH-1:0]   code_q, code_d;
  logic                    strobe_q, strobe_d;
  logic                    busy_q, busy_d;
  logic [POINTS_WIDTH-1:0] index_q, index_d;
  logic                    irq_q, irq_d;
  logic [DWELL_WIDTH-1:0]  dwell_cnt_q, dwell_cnt_d;

  // Shadow configuration, only writable while idle.
  logic [CODE_WIDTH-1:0]   sh_start_q, sh_start_d;
  logic [CODE_WIDTH-1:0]   sh_step_q, sh_step_d;
  logic [POINTS_WIDTH-1:0] sh_points_q, sh_points_d;
  logic [DWELL_WIDTH-1:0]  sh_dwell_q, sh_dwell_d;
  logic                    sweep_cont;

`ifdef DDS_SWEEP_CONTINUOUS_EN
  logic sh_cont_q, sh_cont_d;
  assign sweep_cont = sh_cont_q;
`else
  assign sweep_cont = 1'b0;
`endif

  // Zero point/dwell counts behave as one, so the terminal values are P-1 and D-1.
  logic [POINTS_WIDTH-1:0] last_index;
  logic [DWELL_WIDTH-1:0]  dwell_reload;
  logic                    irq_set;

  assign last_index   = (sh_points_q == '0) ? '0 : sh_points_q - POINTS_WIDTH'(1);
  assign dwell_reload = (sh_dwell_q == '0) ? '0 : sh_dwell_q - DWELL_WIDTH'(1);

  // Next-state logic for the sweep sequencer, shadow registers and interrupt.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    strobe_d    = 1'b0;
    busy_d      = busy_q;
    index_d     = index_q;
    dwell_cnt_d = dwell_cnt_q;
    sh_start_d  = sh_start_q;
    sh_step_d   = sh_step_q;
    sh_points_d = sh_points_q;
    sh_dwell_d  = sh_dwell_q;
`ifdef DDS_SWEEP_CONTINUOUS_EN
    sh_cont_d   = sh_cont_q;
`endif
    irq_set     = 1'b0;

    case (state_q)
      StIdle: begin
        if (abort) begin
          // Abort while idle blocks every other request this cycle.
          state_d = StIdle;
        end else if (start) begin
          // Uses the current shadow values even if cfg_we is also high.
          code_d      = sh_start_q;
          index_d     = '0;
          dwell_cnt_d = dwell_reload;
          strobe_d    = 1'b1;
          busy_d      = 1'b1;
          state_d     = StRun;
        end else if (fixed_we) begin
          code_d   = fixed_code;
          strobe_d = 1'b1;
        end else if (cfg_we) begin
          sh_start_d  = cfg_start_code;
          sh_step_d   = cfg_step_code;
          sh_points_d = cfg_points;
          sh_dwell_d  = cfg_dwell;
`ifdef DDS_SWEEP_CONTINUOUS_EN
          sh_cont_d   = cfg_continuous;
`endif
        end
      end
      StRun: begin
        if (abort) begin
          // Code and index hold; the sweep did not complete, so no interrupt.
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - DWELL_WIDTH'(1);
        end else if (index_q != last_index) begin
          code_d      = code_q + sh_step_q;
          index_d     = index_q + POINTS_WIDTH'(1);
          dwell_cnt_d = dwell_reload;
          strobe_d    = 1'b1;
        end else if (sweep_cont) begin
          code_d      = sh_start_q;
          index_d     = '0;
          dwell_cnt_d = dwell_reload;
          strobe_d    = 1'b1;
          irq_set     = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = StIdle;
          irq_set = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase

    // Setting the interrupt takes priority over clearing it.
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (irq_clear) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      code_q      <= '0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      index_q     <= '0;
      irq_q       <= 1'b0;
      dwell_cnt_q <= '0;
      sh_start_q  <= '0;
      sh_step_q   <= '0;
      sh_points_q <= POINTS_WIDTH'(1);
      sh_dwell_q  <= DWELL_WIDTH'(1);
`ifdef DDS_SWEEP_CONTINUOUS_EN
      sh_cont_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      index_q     <= index_d;
      irq_q       <= irq_d;
      dwell_cnt_q <= dwell_cnt_d;
      sh_start_q  <= sh_start_d;
      sh_step_q   <= sh_step_d;
      sh_points_q <= sh_points_d;
      sh_dwell_q  <= sh_dwell_d;
`ifdef DDS_SWEEP_CONTINUOUS_EN
      sh_cont_q   <= sh_cont_d;
`endif
    end
  end

  assign dds_code    = code_q;
  assign code_strobe = strobe_q;
  assign busy        = busy_q;
  assign point_index = index_q;
  assign interrupt   = irq_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Bench for dds_sweep_controller: directed scenarios plus randomized traffic.
// The reference model describes each sweep by the elapsed time since it started.
// Continuous-mode cases apply when DDS_SWEEP_CONTINUOUS_EN is defined.
module tb_dds_sweep_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [31:0] cfg_start_code;
  logic [31:0] cfg_step_code;
  logic [15:0] cfg_points;
  logic [31:0] cfg_dwell;
`ifdef DDS_SWEEP_CONTINUOUS_EN
  logic        cfg_continuous;
`endif
  logic        fixed_we;
  logic [31:0] fixed_code;
  logic        start;
  logic        abort;
  logic        irq_clear;
  logic [31:0] dds_code;
  logic        code_strobe;
  logic        busy;
  logic [15:0] point_index;
  logic        interrupt;

  dds_sweep_controller dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_start_code (cfg_start_code),
    .cfg_step_code  (cfg_step_code),
    .cfg_points     (cfg_points),
    .cfg_dwell      (cfg_dwell),
`ifdef DDS_SWEEP_CONTINUOUS_EN
    .cfg_continuous (cfg_continuous),
`endif
    .fixed_we       (fixed_we),
    .fixed_code     (fixed_code),
    .start          (start),
    .abort          (abort),
    .irq_clear      (irq_clear),
    .dds_code       (dds_code),
    .code_strobe    (code_strobe),
    .busy           (busy),
    .point_index    (point_index),
    .interrupt      (interrupt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", tag, $time, obs, exp);
  endtask

  // Reference model: shadow config plus a snapshot of the active sweep.
  logic [31:0] sh_start, sh_step;
  int unsigned sh_points, sh_dwell;
  bit          sh_cont;
  logic [31:0] m_start, m_step, m_code;
  int unsigned m_p, m_d, m_t, m_idx;
  bit          m_run, m_cont, m_irq, m_strobe;

  task automatic model_step();
    bit set_now = 1'b0;
    m_strobe = 1'b0;
    if (rst) begin
      sh_start = 0; sh_step = 0; sh_points = 1; sh_dwell = 1; sh_cont = 0;
      m_code = 0; m_idx = 0; m_run = 0; m_irq = 0;
      return;
    end
    if (!m_run) begin
      if (abort) begin
      end else if (start) begin
        m_p = (sh_points == 0) ? 1 : sh_points;
        m_d = (sh_dwell == 0) ? 1 : sh_dwell;
        m_start = sh_start; m_step = sh_step; m_cont = sh_cont;
        m_run = 1; m_t = 0; m_idx = 0; m_code = m_start; m_strobe = 1;
      end else if (fixed_we) begin
        m_code = fixed_code; m_strobe = 1;
      end else if (cfg_we) begin
        sh_start = cfg_start_code; sh_step = cfg_step_code;
        sh_points = cfg_points; sh_dwell = cfg_dwell;
`ifdef DDS_SWEEP_CONTINUOUS_EN
        sh_cont = cfg_continuous;
`else
        sh_cont = 0;
`endif
      end
    end else if (abort) begin
      m_run = 0;
    end else begin
      m_t++;
      if (m_t == m_p * m_d) begin
        set_now = 1;
        if (m_cont) begin
          m_t = 0; m_idx = 0; m_code = m_start; m_strobe = 1;
        end else begin
          m_run = 0;
        end
      end else begin
        m_idx    = m_t / m_d;
        m_code   = m_start + 32'(m_idx) * m_step;
        m_strobe = (m_t % m_d) == 0;
      end
    end
    if (set_now) m_irq = 1;
    else if (irq_clear) m_irq = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("dds_code", dds_code, m_code);
    check_val("code_strobe", 32'(code_strobe), 32'(m_strobe));
    check_val("busy", 32'(busy), 32'(m_run));
    check_val("point_index", 32'(point_index), m_idx);
    check_val("interrupt", 32'(interrupt), 32'(m_irq));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; cfg_we = 0; fixed_we = 0; start = 0; abort = 0; irq_clear = 0;
  endtask

  task automatic load_cfg(input logic [31:0] s, input logic [31:0] st, input logic [15:0] p,
                          input logic [31:0] d, input bit c);
    cfg_start_code = s; cfg_step_code = st; cfg_points = p; cfg_dwell = d;
`ifdef DDS_SWEEP_CONTINUOUS_EN
    cfg_continuous = c;
`else
    if (c) $display("note: continuous request ignored in this build");
`endif
    cfg_we = 1; tick(); cfg_we = 0;
  endtask

  task automatic go();
    start = 1; tick(); start = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1; cfg_start_code = 0; cfg_step_code = 0; cfg_points = 0; cfg_dwell = 0;
    fixed_code = 0;
`ifdef DDS_SWEEP_CONTINUOUS_EN
    cfg_continuous = 0;
`endif
    @(negedge clk);
    tick();
    rst = 0;

    // Reset in the middle of a sweep.
    load_cfg(32'h1234, 32'h1, 16'd4, 32'd3, 0);
    go();
    repeat (3) tick();
    rst = 1; tick(); rst = 0;
    check_val("t1_code", dds_code, 32'h0);
    check_val("t1_busy", 32'(busy), 32'h0);
    check_val("t1_irq", 32'(interrupt), 32'h0);

    // Four-point sweep, dwell 3.
    load_cfg(32'h1000, 32'h10, 16'd4, 32'd3, 0);
    go();
    check_val("t2_first", dds_code, 32'h1000);
    repeat (9) tick();
    check_val("t2_last", dds_code, 32'h1030);
    check_val("t2_last_strobe", 32'(code_strobe), 32'h1);
    repeat (3) tick();
    check_val("t2_done_busy", 32'(busy), 32'h0);
    check_val("t2_done_irq", 32'(interrupt), 32'h1);

    // Negative step wraps around zero.
    irq_clear = 1; tick(); irq_clear = 0;
    load_cfg(32'h8, 32'hFFFF_FFF0, 16'd2, 32'd1, 0);
    go();
    tick();
    check_val("t3_wrap", dds_code, 32'hFFFF_FFF8);
    tick();
    check_val("t3_irq", 32'(interrupt), 32'h1);

    // Abort at point 2; writes during the sweep are ignored.
    irq_clear = 1; tick(); irq_clear = 0;
    load_cfg(32'h100, 32'h1, 16'd4, 32'd2, 0);
    go();
    cfg_start_code = 32'hDEAD; cfg_we = 1; fixed_code = 32'hBEEF; fixed_we = 1;
    repeat (4) tick();
    cfg_we = 0; fixed_we = 0;
    check_val("t4_idx", 32'(point_index), 32'h2);
    abort = 1; tick(); abort = 0;
    check_val("t4_busy", 32'(busy), 32'h0);
    check_val("t4_code", dds_code, 32'h102);
    check_val("t4_irq", 32'(interrupt), 32'h0);
    go();
    check_val("t4_old_shadow", dds_code, 32'h100);
    abort = 1; tick(); abort = 0;

    // Zero points and dwell; irq_clear on the setting edge loses.
    load_cfg(32'h55, 32'h1, 16'd0, 32'd0, 0);
    go();
    irq_clear = 1; tick(); irq_clear = 0;
    check_val("t5_irq", 32'(interrupt), 32'h1);
    check_val("t5_busy", 32'(busy), 32'h0);

`ifdef DDS_SWEEP_CONTINUOUS_EN
    load_cfg(32'hA0, 32'h5, 16'd2, 32'd2, 1);
    go();
    repeat (4) tick();
    check_val("t6_wrap_code", dds_code, 32'hA0);
    check_val("t6_irq", 32'(interrupt), 32'h1);
    repeat (3) tick();
    abort = 1; tick(); abort = 0;
    check_val("t6_abort", 32'(busy), 32'h0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      start          = ($urandom_range(0, 5) == 0);
      abort          = ($urandom_range(0, 24) == 0);
      fixed_we       = ($urandom_range(0, 5) == 0);
      cfg_we         = ($urandom_range(0, 3) == 0);
      irq_clear      = ($urandom_range(0, 9) == 0);
      fixed_code     = $urandom;
      cfg_start_code = $urandom;
      cfg_step_code  = $urandom;
      cfg_points     = 16'($urandom_range(0, 5));
      cfg_dwell      = $urandom_range(0, 4);
`ifdef DDS_SWEEP_CONTINUOUS_EN
      cfg_continuous = ($urandom_range(0, 3) == 0);
`endif
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
